// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: dealer FSM states, rank constants and the
// rank-to-value mapping used by the card dealer.
package blackjack_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAW,
    S_SCAN,
    S_SHUFFLE
  } state_t;

  localparam logic [3:0] RANK_ACE  = 4'd1;
  localparam logic [3:0] RANK_JACK = 4'd11;
  localparam logic [3:0] RANK_KING = 4'd13;

  localparam int CARDS_PER_DECK = 52;

  // Ace counts high (11); face cards collapse to 10.
  function automatic logic [4:0] rank_to_value(input logic [3:0] rank);
    if (rank == RANK_ACE)
      return 5'd11;
    else if (rank >= 4'd10)
      return 5'd10;
    else
      return {1'b0, rank};
  endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/response bundle between the game controller (master) and the card
// dealer (slave).
interface card_dealer_if
  import blackjack_pkg::*;
#(
  parameter int DECKS = 1
);
  localparam int CL_W = $clog2(CARDS_PER_DECK * DECKS + 1);

  logic            deal_req;
  logic            shuffle_req;
  logic            card_valid;
  logic [3:0]      card_rank;
  logic [4:0]      card_value;
  logic [CL_W-1:0] cards_left;
  logic            busy;
  logic            deck_empty;

  modport master (
    output deal_req, shuffle_req,
    input  card_valid, card_rank, card_value, cards_left, busy, deck_empty
  );

  modport slave (
    input  deal_req, shuffle_req,
    output card_valid, card_rank, card_value, cards_left, busy, deck_empty
  );
endinterface

// File: rtl/card_dealer_tracker.sv
// Per-rank usage bookkeeping for the shoe: availability lookup, increment on
// deal and one-rank-per-cycle clear during reshuffle.
module deck_tracker
  import blackjack_pkg::*;
#(
  parameter int DECKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] chk_idx,
  output logic       avail,
  input  logic       inc_en,
  input  logic       clr_en,
  input  logic [3:0] clr_idx
);
  localparam int UW = $clog2(4 * DECKS + 1);
  localparam logic [UW-1:0] COPIES = UW'(4 * DECKS);

  logic [UW-1:0] used [1:13];

  // Ranks 0, 14 and 15 are never available, so a bad generator value fails.
  always_comb begin
    avail = 1'b0;
    if (chk_idx >= RANK_ACE && chk_idx <= RANK_KING)
      avail = (used[chk_idx] < COPIES);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i <= 13; i++)
        used[i] <= '0;
    end else begin
      if (inc_en)
        used[chk_idx] <= used[chk_idx] + UW'(1);
      if (clr_en && clr_idx >= RANK_ACE && clr_idx <= RANK_KING)
        used[clr_idx] <= '0;
    end
  end
endmodule

// File: rtl/card_dealer.sv
// Blackjack card dealer: random draw with bounded retries, deterministic
// fallback scan, and a 13-cycle reshuffle of the shoe.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter int DECKS     = 1,
  parameter int MAX_TRIES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rnd,
  card_dealer_if.slave bus
);
  localparam int CL_W = $clog2(CARDS_PER_DECK * DECKS + 1);
  localparam int TW   = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [CL_W-1:0] FULL      = CL_W'(CARDS_PER_DECK * DECKS);
  localparam logic [TW-1:0]   LAST_TRY  = TW'(MAX_TRIES - 1);

  state_t          state;
  logic [TW-1:0]   tries;
  logic [3:0]      idx;
  logic            card_valid;
  logic [3:0]      card_rank;
  logic [4:0]      card_value;
  logic [CL_W-1:0] cards_left;

  logic [3:0] chk_idx;
  logic       avail;
  logic       deal_now;
  logic       deck_empty;

  assign deck_empty = (cards_left == '0);
  assign chk_idx    = (state == S_DRAW) ? rnd : idx;
  assign deal_now   = avail && (state == S_DRAW || state == S_SCAN);

  deck_tracker #(.DECKS(DECKS)) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .chk_idx (chk_idx),
    .avail   (avail),
    .inc_en  (deal_now),
    .clr_en  (state == S_SHUFFLE),
    .clr_idx (idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      tries      <= '0;
      idx        <= RANK_ACE;
      card_valid <= 1'b0;
      card_rank  <= RANK_ACE;
      card_value <= 5'd11;
      cards_left <= FULL;
    end else begin
      card_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.shuffle_req) begin
            state <= S_SHUFFLE;
            idx   <= RANK_ACE;
          end else if (bus.deal_req && !deck_empty) begin
            state <= S_DRAW;
            tries <= '0;
          end
        end
        S_DRAW: begin
          if (deal_now) begin
            card_valid <= 1'b1;
            card_rank  <= chk_idx;
            card_value <= rank_to_value(chk_idx);
            cards_left <= cards_left - CL_W'(1);
            state      <= S_IDLE;
          end else if (tries == LAST_TRY) begin
            state <= S_SCAN;
            idx   <= RANK_ACE;
          end else begin
            tries <= tries + TW'(1);
          end
        end
        // A non-empty shoe guarantees some rank in 1..13 is available.
        S_SCAN: begin
          if (deal_now) begin
            card_valid <= 1'b1;
            card_rank  <= chk_idx;
            card_value <= rank_to_value(chk_idx);
            cards_left <= cards_left - CL_W'(1);
            state      <= S_IDLE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        S_SHUFFLE: begin
          if (idx == RANK_KING) begin
            cards_left <= FULL;
            state      <= S_IDLE;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.card_valid = card_valid;
  assign bus.card_rank  = card_rank;
  assign bus.card_value = card_value;
  assign bus.cards_left = cards_left;
  assign bus.busy       = (state != S_IDLE);
  assign bus.deck_empty = deck_empty;
endmodule
